// File: rtl/clause_coefficient_bank.sv
// Bank of clause coefficient vectors with addressed/streaming load,
// one-cycle random-access read, loaded tracking and a sweep clear.
module clause_coefficient_bank #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT = 2,
    parameter int NUMBER_OF_INTEGER_VARIABLES              = 2,
    parameter int NUMBER_OF_CLAUSES                        = 4,
    parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX           = 2,
    localparam int ENTRY_W = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT
                             * (NUMBER_OF_INTEGER_VARIABLES + 1),
    localparam int IDX_W   = MAX_BIT_WIDTH_OF_CLAUSES_INDEX
) (
    input  logic                         in_clk,
    input  logic                         in_reset,
    input  logic                         in_clear,
    input  logic                         in_load_start,
    input  logic                         in_wr_valid,
    output logic                         out_wr_ready,
    input  logic [IDX_W-1:0]             in_clause_index,
    input  logic [ENTRY_W-1:0]           in_clause_coefficients,
    input  logic                         in_rd_en,
    input  logic [IDX_W-1:0]             in_rd_index,
    output logic                         out_rd_valid,
    output logic [ENTRY_W-1:0]           out_rd_coefficients,
    output logic                         out_rd_loaded,
    output logic [NUMBER_OF_CLAUSES-1:0] out_valid_map,
    output logic [IDX_W:0]               out_clause_count,
    output logic                         out_load_done,
    output logic                         out_index_error,
    output logic                         out_busy
);

    localparam int NC = NUMBER_OF_CLAUSES;
    localparam logic [IDX_W:0]   NC_W = (IDX_W + 1)'(NC);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NC - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CLEAR
    } state_t;

    state_t             state;
    logic [ENTRY_W-1:0] bank [NC];
    logic [NC-1:0]      valid_map;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   sweep;
    logic               accept;
    logic               wr_in_range;
    logic               rd_in_range;

    // A start/clear request owns the cycle, so no beat is taken alongside it.
    assign out_wr_ready = (state != CLEAR) && !in_clear && !in_load_start;
    assign accept       = in_wr_valid && out_wr_ready;
    assign wr_in_range  = {1'b0, in_clause_index} < NC_W;
    assign rd_in_range  = {1'b0, in_rd_index} < NC_W;
    assign out_valid_map = valid_map;
    assign out_busy      = state != IDLE;

    always_comb begin
        out_clause_count = '0;
        for (int i = 0; i < NC; i++) begin
            out_clause_count = out_clause_count + (IDX_W + 1)'(valid_map[i]);
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state               <= IDLE;
            ptr                 <= '0;
            sweep               <= '0;
            valid_map           <= '0;
            out_rd_valid        <= 1'b0;
            out_rd_coefficients <= '0;
            out_rd_loaded       <= 1'b0;
            out_load_done       <= 1'b0;
            out_index_error     <= 1'b0;
            for (int i = 0; i < NC; i++) begin
                bank[i] <= '0;
            end
        end else begin
            out_load_done   <= 1'b0;
            out_rd_valid    <= in_rd_en;
            out_index_error <= (in_rd_en && !rd_in_range)
                             || (accept && state == IDLE && !wr_in_range);
            // Reads see contents from before any write on this edge.
            if (in_rd_en) begin
                out_rd_coefficients <= rd_in_range ? bank[in_rd_index] : '0;
                out_rd_loaded       <= rd_in_range && valid_map[in_rd_index];
            end
            unique case (state)
                IDLE: begin
                    if (in_clear) begin
                        state <= CLEAR;
                        sweep <= '0;
                    end else if (in_load_start) begin
                        state <= STREAM;
                        ptr   <= '0;
                    end else if (accept && wr_in_range) begin
                        bank[in_clause_index]      <= in_clause_coefficients;
                        valid_map[in_clause_index] <= 1'b1;
                    end
                end
                STREAM: begin
                    if (in_clear) begin
                        state <= CLEAR;
                        sweep <= '0;
                    end else if (in_load_start) begin
                        ptr <= '0;
                    end else if (accept) begin
                        bank[ptr]      <= in_clause_coefficients;
                        valid_map[ptr] <= 1'b1;
                        if (ptr == LAST) begin
                            state         <= IDLE;
                            ptr           <= '0;
                            out_load_done <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    bank[sweep]      <= '0;
                    valid_map[sweep] <= 1'b0;
                    if (sweep == LAST) begin
                        state <= IDLE;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_coefficient_bank.sv
// Directed bench for clause_coefficient_bank with a per-cycle
// behavioural model for the default bank and literal checks for a 3-deep bank.
module tb_clause_coefficient_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0, load_start = 1'b0, wr_valid = 1'b0, rd_en = 1'b0;
    logic [1:0] wr_index = '0, rd_index = '0;
    logic [5:0] wr_data = '0;
    logic       wr_ready, rd_valid, rd_loaded, load_done, index_error, busy;
    logic [5:0] rd_data;
    logic [3:0] valid_map;
    logic [2:0] clause_count;

    logic       s3_wr_valid = 1'b0, s3_rd_en = 1'b0;
    logic [1:0] s3_wr_index = '0, s3_rd_index = '0;
    logic [5:0] s3_wr_data = '0;
    logic       s3_ready, s3_rd_valid, s3_rd_loaded, s3_done, s3_err, s3_busy;
    logic [5:0] s3_rd_data;
    logic [2:0] s3_map;
    logic [2:0] s3_count;

    int checks = 0;
    int fails = 0;

    clause_coefficient_bank dut (
        .in_clk(clk), .in_reset(rst), .in_clear(clear),
        .in_load_start(load_start), .in_wr_valid(wr_valid),
        .out_wr_ready(wr_ready), .in_clause_index(wr_index),
        .in_clause_coefficients(wr_data), .in_rd_en(rd_en),
        .in_rd_index(rd_index), .out_rd_valid(rd_valid),
        .out_rd_coefficients(rd_data), .out_rd_loaded(rd_loaded),
        .out_valid_map(valid_map), .out_clause_count(clause_count),
        .out_load_done(load_done), .out_index_error(index_error),
        .out_busy(busy)
    );

    clause_coefficient_bank #(.NUMBER_OF_CLAUSES(3)) dut3 (
        .in_clk(clk), .in_reset(rst), .in_clear(1'b0),
        .in_load_start(1'b0), .in_wr_valid(s3_wr_valid),
        .out_wr_ready(s3_ready), .in_clause_index(s3_wr_index),
        .in_clause_coefficients(s3_wr_data), .in_rd_en(s3_rd_en),
        .in_rd_index(s3_rd_index), .out_rd_valid(s3_rd_valid),
        .out_rd_coefficients(s3_rd_data), .out_rd_loaded(s3_rd_loaded),
        .out_valid_map(s3_map), .out_clause_count(s3_count),
        .out_load_done(s3_done), .out_index_error(s3_err),
        .out_busy(s3_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents, loaded flags, clear cycles left, stream slot.
    int m_bank [4] = '{0, 0, 0, 0};
    bit m_ld [4] = '{0, 0, 0, 0};
    int clr_left = 0;
    int sptr = -1;
    bit e_rv = 0, e_rl = 0, e_done = 0, e_err = 0;
    int e_rd = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_bank[i] = 0;
                m_ld[i] = 0;
            end
            clr_left = 0; sptr = -1;
            e_rv = 0; e_rl = 0; e_rd = 0; e_done = 0; e_err = 0;
        end else begin
            e_rv = rd_en; e_done = 0;
            e_err = rd_en && (int'(rd_index) >= 4);
            if (rd_en) begin
                e_rd = m_bank[rd_index];
                e_rl = m_ld[rd_index];
            end
            if (clr_left > 0) begin
                m_bank[4 - clr_left] = 0;
                m_ld[4 - clr_left] = 0;
                clr_left--;
            end else if (clear) begin
                clr_left = 4; sptr = -1;
            end else if (load_start) begin
                sptr = 0;
            end else if (wr_valid) begin
                if (sptr >= 0) begin
                    m_bank[sptr] = int'(wr_data);
                    m_ld[sptr] = 1;
                    sptr++;
                    if (sptr == 4) begin
                        sptr = -1; e_done = 1;
                    end
                end else begin
                    m_bank[wr_index] = int'(wr_data);
                    m_ld[wr_index] = 1;
                end
            end
        end
    end

    initial forever begin
        int map, cnt;
        @(negedge clk);
        map = 0; cnt = 0;
        for (int i = 0; i < 4; i++) begin
            map = map | (int'(m_ld[i]) << i);
            cnt = cnt + int'(m_ld[i]);
        end
        chk("m_ready", 32'(wr_ready),
            32'(clr_left == 0 && !clear && !load_start));
        chk("m_busy", 32'(busy), 32'(clr_left > 0 || sptr >= 0));
        chk("m_map", 32'(valid_map), map);
        chk("m_count", 32'(clause_count), cnt);
        chk("m_done", 32'(load_done), 32'(e_done));
        chk("m_err", 32'(index_error), 32'(e_err));
        chk("m_rd_valid", 32'(rd_valid), 32'(e_rv));
        if (e_rv) begin
            chk("m_rd_data", 32'(rd_data), e_rd);
            chk("m_rd_loaded", 32'(rd_loaded), 32'(e_rl));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [5:0] d);
        wr_valid = 1'b1; wr_index = idx; wr_data = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] idx);
        rd_en = 1'b1; rd_index = idx;
        cyc();
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_ready", 32'(wr_ready), 1);
        chk("rst_count", 32'(clause_count), 0);
        chk("rst_busy", 32'(busy), 0);
        rd(2);
        chk("rst_rd_valid", 32'(rd_valid), 1);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_loaded", 32'(rd_loaded), 0);

        wr(1, 6'h2D);
        wr(3, 6'h15);
        wr(1, 6'h07);
        chk("addr_count", 32'(clause_count), 2);
        chk("addr_map", 32'(valid_map), 'b1010);
        rd(1);
        chk("addr_rd1", 32'(rd_data), 'h07);
        chk("addr_rd1_loaded", 32'(rd_loaded), 1);

        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("stream_busy", 32'(busy), 1);
        wr(2'd3, 6'h01);
        wr(2'd3, 6'h02);
        cyc(); cyc();
        chk("stream_gap_done", 32'(load_done), 0);
        wr(2'd3, 6'h03);
        wr(2'd3, 6'h04);
        chk("stream_done", 32'(load_done), 1);
        chk("stream_map", 32'(valid_map), 'hF);
        chk("stream_count", 32'(clause_count), 4);
        cyc();
        chk("stream_done_pulse", 32'(load_done), 0);
        rd(2);
        chk("stream_rd2", 32'(rd_data), 'h03);

        clear = 1'b1;
        cyc();
        clear = 1'b0;
        wr_valid = 1'b1; wr_index = 0; wr_data = 6'h3F;
        for (int i = 0; i < 4; i++) begin
            chk("clr_busy", 32'(busy), 1);
            chk("clr_ready", 32'(wr_ready), 0);
            cyc();
        end
        wr_valid = 1'b0;
        chk("clr_idle", 32'(busy), 0);
        chk("clr_map", 32'(valid_map), 0);
        chk("clr_count", 32'(clause_count), 0);
        rd(0);
        chk("clr_rd0", 32'(rd_data), 0);
        chk("clr_rd0_loaded", 32'(rd_loaded), 0);

        wr(0, 6'h11);
        wr_valid = 1'b1; wr_index = 0; wr_data = 6'h22;
        rd_en = 1'b1; rd_index = 0;
        cyc();
        wr_valid = 1'b0; rd_en = 1'b0;
        chk("rbw_old", 32'(rd_data), 'h11);
        rd(0);
        chk("rbw_new", 32'(rd_data), 'h22);

        s3_wr_valid = 1'b1; s3_wr_index = 3; s3_wr_data = 6'h2A;
        cyc();
        s3_wr_valid = 1'b0;
        chk("n3_wr_err", 32'(s3_err), 1);
        chk("n3_wr_count", 32'(s3_count), 0);
        chk("n3_wr_map", 32'(s3_map), 0);
        s3_wr_valid = 1'b1; s3_wr_index = 2; s3_wr_data = 6'h05;
        cyc();
        s3_wr_valid = 1'b0;
        chk("n3_err_clear", 32'(s3_err), 0);
        chk("n3_count", 32'(s3_count), 1);
        s3_rd_en = 1'b1; s3_rd_index = 3;
        cyc();
        s3_rd_en = 1'b0;
        chk("n3_rd_err", 32'(s3_err), 1);
        chk("n3_rd_valid", 32'(s3_rd_valid), 1);
        chk("n3_rd_data", 32'(s3_rd_data), 0);
        chk("n3_rd_loaded", 32'(s3_rd_loaded), 0);

        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        wr(2'd0, 6'h0A);
        wr(2'd0, 6'h0B);
        chk("pre_rst_map", 32'(valid_map), 'h3);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_map", 32'(valid_map), 0);
        chk("rst_mid_count", 32'(clause_count), 0);
        chk("rst_mid_ready", 32'(wr_ready), 1);
        cyc();
        rst = 1'b0;
        repeat (3) begin
            cyc();
            chk("rst_mid_no_done", 32'(load_done), 0);
        end
        rd(0);
        chk("rst_mid_rd0", 32'(rd_data), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
